// File: rtl/demo_seq_pkg.sv
// demo_seq_pkg: scene table, fade limits and sequencer state type for demo_scene_sequencer.
package demo_seq_pkg;
  typedef enum logic [1:0] {FADE_IN, HOLD, FADE_OUT} seq_state_e;
  localparam int SCENE_COUNT = 4;
  localparam logic [7:0] SCENE_FRAMES [SCENE_COUNT] = '{8'd8, 8'd16, 8'd8, 8'd16};
  localparam logic [9:0] SCROLL_DX [SCENE_COUNT] = '{10'd1, 10'd2, 10'd0, 10'd3};
  localparam logic [1:0] FADE_MAX = 2'd3;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: registered previous value, one-cycle pulse on a 0->1 transition of d_i.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);
  logic prev_q;
  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else prev_q <= d_i;
  end
  assign rise_o = d_i & ~prev_q;
endmodule

// File: rtl/demo_scene_sequencer.sv
// demo_scene_sequencer: per-frame scene/fade/scroll scheduler driven by vsync ticks.
// Define DEMO_STEP_EN to enable manual scene advance on a rising edge of step.
module demo_scene_sequencer
  import demo_seq_pkg::*;
#(
  parameter int NUM_SCENES  = SCENE_COUNT,
  parameter int STEP_FRAMES = 4,
  parameter bit VSYNC_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        pause,
  input  logic        step,
  output logic [2:0]  scene_id,
  output logic [1:0]  fade,
  output logic [9:0]  scroll_x,
  output logic        scene_start,
  output logic [15:0] frame_count
);
  localparam int SW = $clog2(SCENE_COUNT);
  seq_state_e state_q;
  logic [7:0] step_cnt_q, hold_cnt_q;
  logic [2:0] scene_id_q, scene_d;
  logic [1:0] fade_q;
  logic [9:0] scroll_q;
  logic [15:0] frame_q;
  logic scene_start_q, tick, step_rise, accept, last_step;
  logic [SW-1:0] sidx;
  sync_edge_detect u_vsync (.clk(clk), .reset(reset), .d_i(vsync == VSYNC_POL), .rise_o(tick));
`ifdef DEMO_STEP_EN
  sync_edge_detect u_step (.clk(clk), .reset(reset), .d_i(step), .rise_o(step_rise));
`else
  logic unused_step;
  assign unused_step = step;
  assign step_rise = 1'b0;
`endif
  assign sidx = scene_id_q[SW-1:0];
  assign scene_d = (scene_id_q == 3'(NUM_SCENES - 1)) ? 3'd0 : scene_id_q + 3'd1;
  assign accept = tick & ~pause;
  assign last_step = step_cnt_q == 8'(STEP_FRAMES - 1);
  always_ff @(posedge clk) begin
    scene_start_q <= 1'b0;
    if (reset) begin
      state_q <= FADE_IN;
      step_cnt_q <= 8'd0;
      hold_cnt_q <= 8'd0;
      scene_id_q <= 3'd0;
      fade_q <= 2'd0;
      scroll_q <= 10'd0;
      frame_q <= 16'd0;
    end else if (step_rise) begin
      scene_id_q <= scene_d;
      fade_q <= 2'd0;
      scroll_q <= 10'd0;
      step_cnt_q <= 8'd0;
      state_q <= FADE_IN;
      scene_start_q <= 1'b1;
    end else if (accept) begin
      frame_q <= frame_q + 16'd1;
      scroll_q <= scroll_q + SCROLL_DX[sidx];
      case (state_q)
        FADE_IN: begin
          step_cnt_q <= last_step ? 8'd0 : step_cnt_q + 8'd1;
          if (last_step) fade_q <= fade_q + 2'd1;
          if (last_step && fade_q + 2'd1 == FADE_MAX) begin
            state_q <= HOLD;
            hold_cnt_q <= 8'd0;
          end
        end
        HOLD: begin
          hold_cnt_q <= hold_cnt_q + 8'd1;
          if (hold_cnt_q == SCENE_FRAMES[sidx] - 8'd1) begin
            state_q <= FADE_OUT;
            step_cnt_q <= 8'd0;
          end
        end
        FADE_OUT: begin
          step_cnt_q <= last_step ? 8'd0 : step_cnt_q + 8'd1;
          if (last_step) fade_q <= fade_q - 2'd1;
          // Reaching black ends the scene; the scroll restart overrides this tick's step.
          if (last_step && fade_q == 2'd1) begin
            scene_id_q <= scene_d;
            scroll_q <= 10'd0;
            state_q <= FADE_IN;
            scene_start_q <= 1'b1;
          end
        end
        default: state_q <= FADE_IN;
      endcase
    end
  end
  assign scene_id = scene_id_q;
  assign fade = fade_q;
  assign scroll_x = scroll_q;
  assign scene_start = scene_start_q;
  assign frame_count = frame_q;
endmodule

// File: tb/tb_demo_scene_sequencer.sv
// tb_demo_scene_sequencer: randomized vsync/pause/step stimulus against a scene-timeline model.
module tb_demo_scene_sequencer;
  logic clk = 1'b0, reset = 1'b1, vsync = 1'b1, pause = 1'b0, step = 1'b0;
  logic [2:0] scene_id;
  logic [1:0] fade;
  logic [9:0] scroll_x;
  logic scene_start;
  logic [15:0] frame_count;
  int checks = 0, failures = 0;
  localparam int STEP = 4;
  localparam int SF [4] = '{8, 16, 8, 16};
  localparam int DX [4] = '{1, 2, 0, 3};
`ifdef DEMO_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  int m_scene, m_t, m_frames, m_scroll, m_starts;
  bit m_start;
  always #5 clk = ~clk;
  demo_scene_sequencer dut (
    .clk(clk), .reset(reset), .vsync(vsync), .pause(pause), .step(step),
    .scene_id(scene_id), .fade(fade), .scroll_x(scroll_x),
    .scene_start(scene_start), .frame_count(frame_count)
  );
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int fade_of(input int s, input int t);
    if (t < 3 * STEP) return t / STEP;
    if (t < 3 * STEP + SF[s]) return 3;
    return 3 - (t - 3 * STEP - SF[s]) / STEP;
  endfunction
  task automatic model_reset();
    m_scene = 0; m_t = 0; m_frames = 0; m_scroll = 0; m_starts = 0; m_start = 0;
  endtask
  task automatic next_scene();
    m_scene = (m_scene + 1) % 4; m_t = 0; m_scroll = 0; m_start = 1; m_starts++;
  endtask
  task automatic check_all(input string tag);
    check({tag, ".scene_id"}, int'(scene_id), m_scene);
    check({tag, ".fade"}, int'(fade), fade_of(m_scene, m_t));
    check({tag, ".scroll_x"}, int'(scroll_x), m_scroll);
    check({tag, ".frame_count"}, int'(frame_count), m_frames % 65536);
  endtask
  task automatic do_tick(input bit p, input bit st);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    pause = p; step = st; vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1; step = 1'b0;
    m_start = 0;
    if (st && STEP_EN) next_scene();
    else if (!p) begin
      m_frames++;
      m_scroll = (m_scroll + DX[m_scene]) % 1024;
      m_t++;
      if (m_t == 6 * STEP + SF[m_scene]) next_scene();
    end
    check_all("tick");
    check("tick.scene_start", int'(scene_start), int'(m_start));
    @(negedge clk);
    check("tick.scene_start_drop", int'(scene_start), 0);
    pause = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    model_reset();
    check_all("reset");
    check("reset.scene_start", int'(scene_start), 0);
    reset = 1'b0;
    @(negedge clk);
    check_all("post_reset");
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all("init_reset");
    reset = 1'b0;
    repeat (12) do_tick(1'b0, 1'b0);
    check("fadein_done.fade", int'(fade), 3);
    check("fadein_done.scroll", int'(scroll_x), 12);
    repeat (20) do_tick(1'b0, 1'b0);
    check("scene1.scene_id", int'(scene_id), 1);
    check("scene1.scroll", int'(scroll_x), 0);
    repeat (5) do_tick(1'b1, 1'b0);
    check("paused.frame_count", int'(frame_count), 32);
    repeat (3) do_tick(1'b0, 1'b0);
    check("resumed.frame_count", int'(frame_count), 35);
    repeat (150) do_tick($urandom_range(0, 5) == 0, 1'b0);
    do_reset();
    repeat (144) do_tick(1'b0, 1'b0);
    check("wrap.scene_id", int'(scene_id), 0);
    check("wrap.frame_count", int'(frame_count), 144);
    check("wrap.scene_starts", m_starts, 4);
    do_reset();
    repeat (14) do_tick(1'b0, 1'b0);
    do_tick(1'b0, 1'b1);
    check("step.scene_id", int'(scene_id), STEP_EN ? 1 : 0);
    check("step.frame_count", int'(frame_count), STEP_EN ? 14 : 15);
    do_tick(1'b1, 1'b1);
    check("step_paused.scene_id", int'(scene_id), STEP_EN ? 2 : 0);
    repeat (60) do_tick($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
